// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB definitions for the slave arbiters and payload muxes:
// HTRANS encodings, arbiter state type and a one-hot to index helper.
package ahb_slave_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        NO_OWNER = 2'd0,
        OWNED    = 2'd1,
        LOCKED   = 2'd2
    } arb_state_t;

    // Widest select vector the helper accepts; callers zero-extend.
    localparam int ONEHOT_MAX = 32;

    // ORs the indices of all set bits, so a one-hot input yields its index
    // and the logic stays a flat OR tree.
    function automatic int unsigned onehot_to_index(input logic [ONEHOT_MAX-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            if (onehot[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr,
// wrapping around, returned as a one-hot grant.
module ahb_rr_pick #(
    parameter int CHANNEL_NUM = 4,
    parameter int ID_W        = $clog2(CHANNEL_NUM)
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [ID_W-1:0]        rr_ptr,
    output logic [CHANNEL_NUM-1:0] grant,
    output logic                   valid
);

    logic [CHANNEL_NUM-1:0][ID_W-1:0] cand_idx;

    // cand_idx[gi] is the channel examined at scan position gi.
    for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_cand
        assign cand_idx[gi] = ID_W'((int'(rr_ptr) + gi) % CHANNEL_NUM);
    end

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (!valid && req[cand_idx[i]]) begin
                grant[cand_idx[i]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: selects the address-phase owner feeding the slave
// payload mux and the registered data-phase owner for write data/response.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int MAX_HOLD    = 16,
    parameter int ID_W        = $clog2(CHANNEL_NUM)
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [CHANNEL_NUM-1:0]      req,
    input  logic [CHANNEL_NUM-1:0][1:0] trans,
    input  logic [CHANNEL_NUM-1:0]      lock,
    input  logic                        hready,
    output logic [CHANNEL_NUM-1:0]      addr_sel,
    output logic [CHANNEL_NUM-1:0]      data_sel,
    output logic                        owner_valid,
    output logic [ID_W-1:0]             owner_id
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t             state_reg, state_next;
    logic [ID_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [HOLD_W-1:0]      hold_cnt_reg, hold_cnt_next;
    logic [CHANNEL_NUM-1:0] addr_sel_reg, addr_sel_next;
    logic [CHANNEL_NUM-1:0] data_sel_reg;
    logic [ID_W-1:0]        owner_id_reg, owner_id_next;
    logic                   owner_valid_reg;

    logic [CHANNEL_NUM-1:0] pick_grant;
    logic                   pick_valid;
    logic [ID_W-1:0]        pick_id;

    logic                   own_req;
    logic                   own_lock;
    logic [1:0]             own_trans;
    logic                   own_active;
    logic                   release_owner;
    logic                   arbitrate;
    arb_state_t             keep_state;

    ahb_rr_pick #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .ID_W        (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    assign pick_id = ID_W'(onehot_to_index(ONEHOT_MAX'(pick_grant)));

    assign own_req    = req[owner_id_reg];
    assign own_lock   = lock[owner_id_reg];
    assign own_trans  = trans[owner_id_reg];
    assign own_active = (own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_SEQ);

    // Only a NONSEQ boundary may end a long tenure; BUSY/SEQ keep the burst intact.
    assign release_owner = !own_req
                        || (own_trans == HTRANS_IDLE)
                        || ((MAX_HOLD != 0) && (own_trans == HTRANS_NONSEQ)
                            && (hold_cnt_reg >= HOLD_MAX));

    always_comb begin
        arbitrate  = 1'b0;
        keep_state = state_reg;
        case (state_reg)
            NO_OWNER: arbitrate = 1'b1;
            OWNED:    arbitrate = release_owner;
            LOCKED: begin
                // An asserted lock wins over IDLE or a dropped request.
                if (!own_lock) begin
                    keep_state = OWNED;
                    arbitrate  = release_owner;
                end
            end
            default:  arbitrate = 1'b1;
        endcase
    end

    always_comb begin
        state_next    = keep_state;
        rr_ptr_next   = rr_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        addr_sel_next = addr_sel_reg;
        owner_id_next = owner_id_reg;
        if (arbitrate) begin
            hold_cnt_next = '0;
            if (pick_valid) begin
                state_next    = lock[pick_id] ? LOCKED : OWNED;
                addr_sel_next = pick_grant;
                owner_id_next = pick_id;
                rr_ptr_next   = (pick_id == ID_W'(CHANNEL_NUM - 1)) ? '0 : pick_id + 1'b1;
            end else begin
                state_next    = NO_OWNER;
                addr_sel_next = '0;
                owner_id_next = '0;
            end
        end else if (own_active && (hold_cnt_reg != HOLD_MAX)) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg       <= NO_OWNER;
            rr_ptr_reg      <= '0;
            hold_cnt_reg    <= '0;
            addr_sel_reg    <= '0;
            data_sel_reg    <= '0;
            owner_id_reg    <= '0;
            owner_valid_reg <= 1'b0;
        end else if (hready) begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            hold_cnt_reg    <= hold_cnt_next;
            addr_sel_reg    <= addr_sel_next;
            data_sel_reg    <= addr_sel_reg;
            owner_id_reg    <= owner_id_next;
            owner_valid_reg <= |addr_sel_next;
        end
    end

    assign addr_sel    = addr_sel_reg;
    assign data_sel    = data_sel_reg;
    assign owner_valid = owner_valid_reg;
    assign owner_id    = owner_id_reg;

    a_sel_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
        $onehot0(addr_sel_reg) && $onehot0(data_sel_reg));

    a_owner_match: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (owner_valid_reg == (|addr_sel_reg))
        && (owner_valid_reg ? addr_sel_reg[owner_id_reg] : (owner_id_reg == '0)));

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter: stimulus queues expected selects,
// a monitor pops and compares them after every clock edge.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic [3:0]      req = 4'b0000;
    logic [3:0][1:0] trans = '0;
    logic [3:0]      lock = 4'b0000;
    logic            hready = 1'b1;
    logic [3:0]      addr_sel;
    logic [3:0]      data_sel;
    logic            owner_valid;
    logic [1:0]      owner_id;

    typedef struct {
        logic [3:0] a;
        logic [3:0] d;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] prev_a = 4'b0000;
    logic [3:0] prev_d = 4'b0000;

    ahb_slave_arbiter #(
        .CHANNEL_NUM (4),
        .MAX_HOLD    (4),
        .ID_W        (2)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .req         (req),
        .trans       (trans),
        .lock        (lock),
        .hready      (hready),
        .addr_sel    (addr_sel),
        .data_sel    (data_sel),
        .owner_valid (owner_valid),
        .owner_id    (owner_id)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [1:0] id_of(input logic [3:0] sel);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) id = 2'(i);
        end
        return id;
    endfunction

    function automatic logic [7:0] tr(input int ch, input logic [1:0] v);
        logic [7:0] t;
        t = 8'h00;
        t[2*ch +: 2] = v;
        return t;
    endfunction

    task automatic check(input string nm, input string what, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got %b want %b", nm, what, got, want);
        end
    endtask

    task automatic check_all(input string nm, input logic [3:0] ea, input logic [3:0] ed);
        check(nm, "addr_sel", addr_sel, ea);
        check(nm, "data_sel", data_sel, ed);
        check(nm, "owner_valid", {3'b000, owner_valid}, {3'b000, |ea});
        check(nm, "owner_id", {2'b00, owner_id}, {2'b00, id_of(ea)});
    endtask

    // Called at a negedge: drive, queue expectation for the next edge, return at next negedge.
    task automatic cyc(input string nm, input logic [3:0] r, input logic [7:0] t,
                       input logic [3:0] l, input logic hr, input logic [3:0] ea);
        logic [3:0] ed;
        req    = r;
        trans  = t;
        lock   = l;
        hready = hr;
        ed     = hr ? prev_a : prev_d;
        prev_d = ed;
        prev_a = ea;
        exp_q.push_back('{a: ea, d: ed, name: nm});
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all(e.name, e.a, e.d);
                $display("txn %-14s addr_sel=%b data_sel=%b owner_valid=%b owner_id=%0d",
                         e.name, addr_sel, data_sel, owner_valid, owner_id);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        req = 4'b1111;
        repeat (3) @(negedge HCLK);
        check_all("reset", 4'b0000, 4'b0000);
        HRESETn = 1'b1;

        // 1: first grant after reset goes to ch0, data phase one edge later
        cyc("t1_grant",   4'b1111, tr(0, I), 4'b0000, 1'b1, 4'b0001);
        cyc("t1_data",    4'b1111, tr(0, N), 4'b0000, 1'b1, 4'b0001);
        cyc("t1_end",     4'b0000, tr(0, I), 4'b0000, 1'b1, 4'b0000);

        // 2: round-robin between ch1 and ch3
        cyc("t2_g1",      4'b1010, 8'h00,    4'b0000, 1'b1, 4'b0010);
        cyc("t2_n1",      4'b1010, tr(1, N), 4'b0000, 1'b1, 4'b0010);
        cyc("t2_g3",      4'b1010, tr(1, I), 4'b0000, 1'b1, 4'b1000);
        cyc("t2_n3",      4'b1010, tr(3, N), 4'b0000, 1'b1, 4'b1000);
        cyc("t2_g1b",     4'b1010, tr(3, I), 4'b0000, 1'b1, 4'b0010);
        cyc("t2_n1b",     4'b1010, tr(1, N), 4'b0000, 1'b1, 4'b0010);
        cyc("t2_g3b",     4'b1010, tr(1, I), 4'b0000, 1'b1, 4'b1000);
        cyc("t2_n3b",     4'b1010, tr(3, N), 4'b0000, 1'b1, 4'b1000);
        cyc("t2_end",     4'b0000, tr(3, I), 4'b0000, 1'b1, 4'b0000);

        // 3: wait states freeze selects, then same-edge handover to ch0
        cyc("t3_g2",      4'b0100, 8'h00,    4'b0000, 1'b1, 4'b0100);
        cyc("t3_n2",      4'b0100, tr(2, N), 4'b0000, 1'b1, 4'b0100);
        cyc("t3_s2",      4'b0100, tr(2, S), 4'b0000, 1'b1, 4'b0100);
        cyc("t3_wait1",   4'b0001, 8'h00,    4'b0000, 1'b0, 4'b0100);
        cyc("t3_wait2",   4'b0001, tr(0, N), 4'b0001, 1'b0, 4'b0100);
        cyc("t3_wait3",   4'b0001, 8'h00,    4'b0000, 1'b0, 4'b0100);
        cyc("t3_hand0",   4'b0001, 8'h00,    4'b0000, 1'b1, 4'b0001);
        cyc("t3_n0",      4'b0001, tr(0, N), 4'b0000, 1'b1, 4'b0001);

        // 4: locked owner survives IDLE, releases when lock drops
        cyc("t4_clear",   4'b0000, 8'h00,    4'b0000, 1'b1, 4'b0000);
        cyc("t4_glock",   4'b0001, 8'h00,    4'b0001, 1'b1, 4'b0001);
        cyc("t4_n0",      4'b0011, tr(0, N), 4'b0001, 1'b1, 4'b0001);
        cyc("t4_idle_lk", 4'b0011, tr(0, I), 4'b0001, 1'b1, 4'b0001);
        cyc("t4_busy_lk", 4'b0011, tr(0, B), 4'b0001, 1'b1, 4'b0001);
        cyc("t4_unlock",  4'b0011, tr(0, I), 4'b0000, 1'b1, 4'b0010);
        cyc("t4_end",     4'b0000, 8'h00,    4'b0000, 1'b1, 4'b0000);

        // 5: hold limit of 4 forces re-arbitration at the next NONSEQ only
        cyc("t5_g0",      4'b0001, 8'h00,    4'b0000, 1'b1, 4'b0001);
        cyc("t5_b1",      4'b0101, tr(0, N), 4'b0000, 1'b1, 4'b0001);
        cyc("t5_b2",      4'b0101, tr(0, S), 4'b0000, 1'b1, 4'b0001);
        cyc("t5_b3",      4'b0101, tr(0, S), 4'b0000, 1'b1, 4'b0001);
        cyc("t5_b4",      4'b0101, tr(0, S), 4'b0000, 1'b1, 4'b0001);
        cyc("t5_seq_sat", 4'b0101, tr(0, S), 4'b0000, 1'b1, 4'b0001);
        cyc("t5_busy",    4'b0101, tr(0, B), 4'b0000, 1'b1, 4'b0001);
        cyc("t5_nonseq",  4'b0101, tr(0, N), 4'b0000, 1'b1, 4'b0100);

        // 6: no requesters leaves the slave without an owner
        cyc("t6_none",    4'b0000, 8'h00,    4'b0000, 1'b1, 4'b0000);
        cyc("t6_none2",   4'b0000, 8'hAA,    4'b0000, 1'b1, 4'b0000);

        // 7: asynchronous reset mid-transfer, scan restarts at ch0
        cyc("t7_g1",      4'b0010, 8'h00,    4'b0000, 1'b1, 4'b0010);
        cyc("t7_n1",      4'b1111, tr(1, N), 4'b0000, 1'b1, 4'b0010);
        #2;
        HRESETn = 1'b0;
        #1;
        check_all("t7_async_rst", 4'b0000, 4'b0000);
        @(negedge HCLK);
        prev_a  = 4'b0000;
        prev_d  = 4'b0000;
        HRESETn = 1'b1;
        cyc("t7_regrant", 4'b1111, 8'h00,    4'b0000, 1'b1, 4'b0001);
        cyc("t7_n0",      4'b1111, tr(0, N), 4'b0000, 1'b1, 4'b0001);
        cyc("t7_end",     4'b0000, 8'h00,    4'b0000, 1'b1, 4'b0000);

        repeat (2) @(negedge HCLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending expectations got %0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave arbiter that decides which master channel owns one AHB slave port.
- Produces the one-hot select that drives the slave-side payload mux (address/control/write-data bundle), plus a registered data-phase select for write-data and response routing.
- One instance per slave. It sits directly upstream of that slave's payload mux.
- Round-robin among requesters. Holds ownership across bursts and locked sequences, and forces re-arbitration after a configurable hold limit.

Parameters:
- CHANNEL_NUM, 4: number of master channels competing for this slave.
- MAX_HOLD, 16: maximum consecutive address-phase beats one owner may keep before re-arbitration is forced at its next NONSEQ. 0 disables the limit.
- ID_W, $clog2(CHANNEL_NUM): width of owner_id.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- req  in  CHANNEL_NUM  per-master decoded HSEL for this slave.
- trans  in  CHANNEL_NUM x 2  per-master HTRANS.
- lock  in  CHANNEL_NUM  per-master HMASTLOCK.
- hready  in  1  HREADYOUT of this slave (transfer-complete strobe).
- addr_sel  out  CHANNEL_NUM  one-hot address-phase owner; all-zero means no owner (mux emits '0, i.e. IDLE).
- data_sel  out  CHANNEL_NUM  one-hot data-phase owner.
- owner_valid  out  1  addr_sel is non-zero.
- owner_id  out  ID_W  binary index of the addr_sel owner; 0 when no owner.

Behaviour:
- Reset (async, HRESETn=0):
  - addr_sel=0, data_sel=0, owner_valid=0, owner_id=0.
  - state=NO_OWNER, rr_ptr=0, hold_cnt=0.
- All outputs are registered. Every state change happens only on HCLK rising edges where hready=1. When hready=0, all registers hold.
- States:
  - NO_OWNER: addr_sel=0.
  - OWNED: an owner is held. It is not locked.
  - LOCKED: the owner asserted lock during its address phase. No re-arbitration is allowed.
- Arbitration point (hready=1), evaluated in this order:
  - NO_OWNER: arbitrate.
  - LOCKED: stay while lock[owner]=1. When lock[owner] drops, go to OWNED and evaluate the OWNED rules in the same cycle.
  - OWNED: arbitrate if any of the following hold:
    - req[owner]=0;
    - trans[owner]=IDLE;
    - trans[owner]=NONSEQ and hold_cnt>=MAX_HOLD (MAX_HOLD!=0).
  - OWNED otherwise: keep the owner. BUSY and SEQ never re-arbitrate.
- Arbitration:
  - Pick the first requesting channel (req=1) scanning from rr_ptr upward with wrap-around.
  - If there are no requesters, go to NO_OWNER with addr_sel=0.
  - On a new grant to channel k: rr_ptr<=(k+1) mod CHANNEL_NUM and hold_cnt<=0.
  - If the incumbent is the only requester it may be re-granted. In that case hold_cnt resets.
  - If lock[k]=1 at grant, the next state is LOCKED; otherwise it is OWNED.
- hold_cnt:
  - Increments (saturating at MAX_HOLD) on each hready=1 cycle where trans[owner] is NONSEQ or SEQ.
  - Clears on a new grant.
- data_sel: data_sel<=addr_sel on every hready=1 edge. This gives exactly one accepted-transfer delay, i.e. the AHB address-to-data pipeline.
- Latency: a request seen at edge N with the slave idle gives addr_sel valid after edge N. The first address phase is therefore cycle N+1, and data_sel follows one hready cycle later.
- Wait states: with hready=0, addr_sel and data_sel are frozen regardless of req, trans or lock changes.
- Simultaneous events:
  - If the owner drops req while others request, handover happens at the same edge.
  - If lock and IDLE occur together in LOCKED, the lock takes precedence and the state stays LOCKED.
- Invariants (checked by assertion):
  - addr_sel and data_sel are always one-hot or zero.
  - owner_id matches addr_sel.
- Reset mid-transfer: all selects clear immediately (async). After release, arbitration starts from channel 0.

Decomposition:
- AHB_package holds:
  - the HTRANS constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - the arb_state_t enum {NO_OWNER, OWNED, LOCKED};
  - a onehot-to-index function shared with the muxes.
- Sub-module ahb_rr_pick: purely combinational round-robin picker with inputs req and rr_ptr, outputs a one-hot grant and a valid flag. It is reused by the other slave arbiters.

Test Plan:
1. Reset with req=4'b1111, HRESETn released:
   - first edge gives addr_sel=4'b0001, owner_id=0, rr_ptr=1;
   - the next hready edge gives data_sel=4'b0001.
2. Round-robin: req=4'b1010, each owner sends NONSEQ then IDLE with hready=1 throughout → grant order ch1, ch3, ch1, ch3.
3. Wait states: owner ch2 with hready=0 for 3 cycles while req changes to 4'b0001 → addr_sel=4'b0100 and data_sel unchanged until hready=1, then handover to ch0.
4. Lock:
   - ch0 granted with lock=1, then trans=IDLE, with req[1]=1 → addr_sel stays 4'b0001 while lock=1;
   - the lock drops → grant moves to ch1 at that hready edge.
5. MAX_HOLD=4: ch0 streams SEQ bursts (NONSEQ+3 SEQ repeatedly) with req[2]=1 → after 4 beats the next NONSEQ boundary grants ch2.
6. No requesters: req=0 → addr_sel=0, owner_valid=0; the downstream mux payload is all-zero (HTRANS=IDLE).
